// File: rtl/composite_pkg.sv
// Shared level codes, timing constants and field-state classification
// for the composite video field sequencer.
package composite_pkg;

    localparam logic [2:0] LVL_SYNC  = 3'd0;
    localparam logic [2:0] LVL_BLACK = 3'd1;
    // Indexed by 2-bit pixel intensity: 0 -> 1, 1 -> 2, 2 -> 4, 3 -> 7
    localparam logic [3:0][2:0] PIX_LVL = {3'd7, 3'd4, 3'd2, 3'd1};

    localparam logic [6:0] HSYNC_T = 7'd9;
    localparam logic [5:0] SHORT_T = 6'd5;
    localparam logic [5:0] BROAD_T = 6'd55;
    localparam int         HALF_T  = 64;
    localparam int         LINE_T  = 128;

    localparam logic [9:0] HL_SHORT_PRE  = 10'd5;
    localparam logic [9:0] HL_BLANK      = 10'd10;
    localparam logic [9:0] HL_ACTIVE     = 10'd46;
    localparam logic [9:0] HL_SHORT_POST = 10'd618;
    localparam logic [9:0] HL_FIELD      = 10'd624;

    typedef enum logic [2:0] {
        ST_BROAD,
        ST_SHORT_PRE,
        ST_BLANK,
        ST_ACTIVE,
        ST_SHORT_POST
    } field_state_e;

    function automatic field_state_e state_of_hl(input logic [9:0] hl);
        if (hl < HL_SHORT_PRE)       return ST_BROAD;
        else if (hl < HL_BLANK)      return ST_SHORT_PRE;
        else if (hl < HL_ACTIVE)     return ST_BLANK;
        else if (hl < HL_SHORT_POST) return ST_ACTIVE;
        return ST_SHORT_POST;
    endfunction

endpackage

// File: rtl/line_timer.sv
// Tick (0..127) and half-line (0..623) counters for one progressive field,
// with half-line / line end strobes decoded from the current tick.
module line_timer
    import composite_pkg::*;
(
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       en,
    output logic [6:0] t,
    output logic [9:0] hl,
    output logic [9:0] hl_nxt,
    output logic       half_end,
    output logic       line_end
);

    assign half_end = (t[5:0] == 6'(HALF_T - 1));
    assign line_end = (t == 7'(LINE_T - 1));
    assign hl_nxt   = (hl == HL_FIELD - 10'd1) ? '0 : hl + 10'd1;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t  <= '0;
            hl <= '0;
        end else if (!en) begin
            t  <= '0;
            hl <= '0;
        end else begin
            t <= t + 7'd1;
            if (half_end) hl <= hl_nxt;
        end
    end

endmodule

// File: rtl/composite_field_sequencer.sv
// Field-level sequencer for one 312-line progressive pseudo-PAL field:
// sync/blank/active level selection, pixel handshake and status flags.
//
// state         | meaning
// ST_BROAD      | half-lines 0..4, broad (vertical) sync pulses
// ST_SHORT_PRE  | half-lines 5..9, equalising pulses after broad sync
// ST_BLANK      | half-lines 10..45, blanked lines with hsync only
// ST_ACTIVE     | half-lines 46..617, hsync + pixel window
// ST_SHORT_POST | half-lines 618..623, equalising pulses before next field
module composite_field_sequencer
    import composite_pkg::*;
#(
    parameter int ACT_LINES = 286,
    parameter int ACT_START = 20,
    parameter int ACT_END   = 125
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       en,
    input  logic [1:0] pix_data,
    input  logic       pix_valid,
    input  logic       underrun_clr,
    output logic       pix_req,
    output logic [2:0] sig,
    output logic [8:0] act_line,
    output logic       field_start,
    output logic       underrun
);

    localparam logic [6:0] ACT_START_T = 7'(ACT_START);
    localparam logic [6:0] ACT_END_T   = 7'(ACT_END);
    localparam logic [8:0] LAST_LINE   = 9'(ACT_LINES - 1);

    logic [6:0]   t;
    logic [9:0]   hl;
    logic [9:0]   hl_nxt;
    logic         half_end;
    logic         line_end;
    field_state_e state;
    field_state_e state_nxt;
    logic [5:0]   h;
    logic         in_window;
    logic [2:0]   level_nxt;

    line_timer u_line_timer (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .t         (t),
        .hl        (hl),
        .hl_nxt    (hl_nxt),
        .half_end  (half_end),
        .line_end  (line_end)
    );

    assign h         = t[5:0];
    assign state_nxt = state_of_hl(hl_nxt);
    assign in_window = (state == ST_ACTIVE) && (t >= ACT_START_T) && (t < ACT_END_T);
    assign pix_req   = en && in_window;

    always_comb begin
        level_nxt = LVL_BLACK;
        case (state)
            ST_BROAD:                   if (h < BROAD_T) level_nxt = LVL_SYNC;
            ST_SHORT_PRE, ST_SHORT_POST: if (h < SHORT_T) level_nxt = LVL_SYNC;
            ST_BLANK:                   if (t < HSYNC_T) level_nxt = LVL_SYNC;
            ST_ACTIVE: begin
                if (t < HSYNC_T)
                    level_nxt = LVL_SYNC;
                else if (in_window && pix_valid)
                    level_nxt = PIX_LVL[pix_data];
            end
            default: level_nxt = LVL_BLACK;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_BROAD;
            sig         <= LVL_BLACK;
            field_start <= 1'b0;
            underrun    <= 1'b0;
            act_line    <= '0;
        end else begin
            if (!en) begin
                state       <= ST_BROAD;
                sig         <= LVL_BLACK;
                field_start <= 1'b0;
            end else begin
                sig         <= level_nxt;
                field_start <= (hl == '0) && (t == '0);
                if (half_end) state <= state_nxt;
                // Index restarts on entry and saturates on the last active line
                if (line_end) begin
                    if (state != ST_ACTIVE && state_nxt == ST_ACTIVE)
                        act_line <= '0;
                    else if (state == ST_ACTIVE && act_line != LAST_LINE)
                        act_line <= act_line + 9'd1;
                end
            end
            if (pix_req && !pix_valid)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: doc/composite_field_sequencer.md
Name: composite_field_sequencer

Overview:
- Sequences one progressive 312-line pseudo-PAL (ITU System I) field for the composite video output on the Tang Nano.
- Runs from the 2 MHz timing clock: 1 tick = 0.5 us, 128 ticks per line, 64 ticks per half-line.
- A field-level state machine decides per half-line and line whether to emit broad sync, short (equalising) sync, blanking or active video.
- During active windows it requests pixels from an upstream pixel source and drives the registered 3-bit DAC level code `sig`.

Parameters:
- `ACT_LINES`, 286, active lines per field (the other line/half-line counts are fixed package constants).
- `ACT_START`, 20, first active tick in a line.
- `ACT_END`, 125, first tick after the active window.

Ports:
- `clk` input 1 — 2 MHz timing clock.
- `sys_rst_n` input 1 — asynchronous, active-low reset.
- `en` input 1 — sequencer enable.
- `pix_data` input 2 — pixel intensity from the source.
- `pix_valid` input 1 — `pix_data` valid this cycle.
- `underrun_clr` input 1 — clears the underrun flag.
- `pix_req` output 1 — pixel requested this cycle (combinational).
- `sig` output 3 — registered DAC level code.
- `act_line` output 9 — current active line index, 0..285.
- `field_start` output 1 — one-cycle pulse at the start of a field.
- `underrun` output 1 — sticky pixel-underrun flag.

Behaviour:
- Reset (async, `sys_rst_n` = 0):
  - `sig` = `LVL_BLACK` (3'd1); `pix_req`, `field_start`, `underrun` = 0; `act_line` = 0.
  - Tick counter `t` = 0; half-line counter `hl` = 0; state = `BROAD`.
- Counters:
  - `t` is 7-bit, 0..127, wrapping.
  - `hl` is 10-bit, 0..623: it increments on `t` = 63 and `t` = 127, and wraps 623 → 0.
- State is a function of `hl`, registered on half-line boundaries:
  - `BROAD`: `hl` 0..4.
  - `SHORT_PRE`: `hl` 5..9.
  - `BLANK`: `hl` 10..45 (18 lines).
  - `ACTIVE`: `hl` 46..617 (286 lines).
  - `SHORT_POST`: `hl` 618..623.
  - `SHORT_POST` → `BROAD` on wrap.
- Level per tick (`h` = `t` mod 64):
  - `BROAD`: `LVL_SYNC` (3'd0) for `h` < 55, `LVL_BLACK` otherwise.
  - `SHORT_PRE`/`SHORT_POST`: `LVL_SYNC` for `h` < 5, `LVL_BLACK` otherwise.
  - `BLANK`: `LVL_SYNC` for `t` < 9, `LVL_BLACK` otherwise.
  - `ACTIVE`: `LVL_SYNC` for `t` < 9, `LVL_BLACK` for `t` < `ACT_START` and for `t` >= `ACT_END`; pixel level in between.
- Pixel handshake:
  - `pix_req` = `en` && state == `ACTIVE` && `ACT_START` <= `t` < `ACT_END`, giving exactly 105 requests per active line.
  - The source must present `pix_data` with `pix_valid` in the same cycle.
  - If `pix_valid` = 1: `sig` <= `PIX_LVL[pix_data]`, with 0 → 3'd1, 1 → 3'd2, 2 → 3'd4, 3 → 3'd7.
  - If `pix_valid` = 0: `sig` <= `LVL_BLACK` and `underrun` <= 1.
- Latency: `sig` at edge n+1 reflects the counters and inputs at cycle n (1 cycle).
- `underrun`:
  - Sticky; cleared by `underrun_clr`.
  - If set and clear occur in the same cycle, set wins.
- `act_line`:
  - Increments at `t` = 127 while in `ACTIVE`.
  - Resets to 0 on entry to `ACTIVE`.
  - Holds its value outside `ACTIVE`.
- `field_start`: registered pulse, high for the one cycle in which `sig` shows `hl` = 0, `t` = 0.
- `en` = 0:
  - Synchronously forces counters and state to their reset values, `sig` = `LVL_BLACK`, `pix_req` = 0.
  - Mid-line deassertion takes effect at the next edge.
  - `underrun` is retained.
  - On reassertion, sequencing starts at `hl` = 0, `t` = 0 (a fresh field).
- Async reset mid-field: immediate return to reset values; no partial line is resumed.

Decomposition:
- Package `composite_pkg`:
  - Level codes `LVL_SYNC`, `LVL_BLACK`, `PIX_LVL` table.
  - Timing constants: `HSYNC_T` = 9, `SHORT_T` = 5, `BROAD_T` = 55, `HALF_T` = 64, `LINE_T` = 128.
  - Half-line boundaries 5, 10, 46, 618, 624.
  - State enum.
- Sub-module `line_timer`: owns `t` and `hl`, and emits `half_end`/`line_end` strobes.
- This module: FSM, level mux, handshake, flags.

Test Plan:
- Reset release with `en` = 1 → first `sig` = 0 for 55 cycles, then 3'd1 for 9 cycles, repeated 5 times; `field_start` pulses once.
- Full field, `pix_valid` tied 1 → `field_start` period exactly 39936 cycles; `pix_req` high for 286×105 = 30030 cycles; final `act_line` = 285.
- Active line with `pix_data` ramping 0,1,2,3 → `sig` one cycle later 1,2,4,7; `sig` = 0 at `t` 0..8 and 1 at `t` 9..19 and 125..127.
- `pix_valid` dropped for one cycle at `t` = 60 → `sig` = 1 at `t` = 61; `underrun` = 1 and stays 1 until `underrun_clr` (clr in the same cycle as a new underrun leaves it 1).
- `en` deasserted at `hl` = 300, `t` = 70 → next edge `sig` = 1, `pix_req` = 0; on reassertion the broad-sync pattern restarts and `field_start` pulses.
- `sys_rst_n` pulsed low mid-`ACTIVE` → `sig` = 1 and `act_line` = 0 immediately, without waiting for a clock edge.
